// File: rtl/nanov_serial_alu_pkg.sv
// Shared definitions for the nanoV bit-serial ALU: op codes, FSM states and
// small single-bit helper functions used by the datapath.
package nanov_serial_alu_pkg;

  // Operation codes, shared with the instruction decoder.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_EQ   = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that run the adder as a subtractor (invert b, carry-in of 1).
  function automatic logic op_is_sub(input logic [2:0] op);
    logic r;
    case (op)
      OP_SUB, OP_SLT, OP_SLTU, OP_EQ: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Majority of three bits: the carry out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/nanov_serial_alu.sv
// nanoV bit-serial ALU. Consumes rs1/rs2 bit streams LSB first, one bit per
// cycle for XLEN cycles, and emits the rd bit stream combinationally. Owns the
// bit counter that the register file uses for addressing, and produces a
// registered compare flag for branches and SLT/SLTU.
module nanov_serial_alu
  import nanov_serial_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic [CNT_W-1:0] counter,
  output logic             d_bit,
  output logic             done,
  output logic             cmp
);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             eq_q;
  logic             done_q;
  logic             cmp_q;

  logic             run_s;
  logic             sub_s;
  logic             bb_s;
  logic             sum_s;
  logic             cout_s;
  logic             eq_d;
  logic             last_s;
  logic             d_bit_s;
  logic             cmp_d;

  // One full-adder slice; b is inverted and carry preset to 1 for subtraction.
  assign run_s  = (state_q == ST_RUN);
  assign sub_s  = op_is_sub(op_q);
  assign bb_s   = b_bit ^ sub_s;
  assign sum_s  = a_bit ^ bb_s ^ carry_q;
  assign cout_s = maj3(a_bit, bb_s, carry_q);
  assign eq_d   = eq_q & ~(a_bit ^ b_bit);
  assign last_s = (cnt_q == CNT_W'(XLEN - 1));

  // Result bit for the current position; compare-type ops only report via cmp.
  always_comb begin
    d_bit_s = 1'b0;
    if (run_s) begin
      case (op_q)
        OP_ADD, OP_SUB: d_bit_s = sum_s;
        OP_AND:         d_bit_s = a_bit & b_bit;
        OP_OR:          d_bit_s = a_bit | b_bit;
        OP_XOR:         d_bit_s = a_bit ^ b_bit;
        default:        d_bit_s = 1'b0;
      endcase
    end else begin
      d_bit_s = 1'b0;
    end
  end

  // Compare value as it would stand after the current (sign) bit is folded in.
  always_comb begin
    cmp_d = 1'b0;
    case (op_q)
      // Operand signs differ: a is negative iff a < b. Same sign: a-b cannot
      // overflow, so the difference's sign bit decides.
      OP_SLT:  cmp_d = (a_bit ^ b_bit) ? a_bit : sum_s;
      // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
      OP_SLTU: cmp_d = ~cout_s;
      OP_EQ:   cmp_d = eq_d;
      default: cmp_d = cout_s;
    endcase
  end

  // FSM, bit counter, carry/eq flags and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          cnt_q  <= {CNT_W{1'b0}};
          if (start) begin
            state_q <= ST_RUN;
            op_q    <= op;
            carry_q <= op_is_sub(op);
            eq_q    <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry_q <= cout_s;
          eq_q    <= eq_d;
          if (last_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b1;
            cmp_q   <= cmp_d;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = run_s;
  assign counter = cnt_q;
  assign d_bit   = d_bit_s;
  assign done    = done_q;
  assign cmp     = cmp_q;

endmodule

// File: tb/tb_nanov_serial_alu.sv
// Self-checking bench for nanov_serial_alu: directed cases with literal
// expectations plus randomized operations, all checked every cycle against a
// word-level reference model.
module tb_nanov_serial_alu;
  import nanov_serial_alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  logic             clk   = 1'b0;
  logic             rstn  = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op_in = 3'd0;
  logic [31:0]      cur_a = 32'd0;
  logic [31:0]      cur_b = 32'd0;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic [CNT_W-1:0] counter;
  logic             d_bit;
  logic             done;
  logic             cmp;

  int total = 0;
  int bad   = 0;

  // Register-file stand-in: operand bits selected by the ALU's counter.
  assign a_bit = cur_a[counter];
  assign b_bit = cur_b[counter];

  nanov_serial_alu #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .op      (op_in),
    .a_bit   (a_bit),
    .b_bit   (b_bit),
    .busy    (busy),
    .counter (counter),
    .d_bit   (d_bit),
    .done    (done),
    .cmp     (cmp)
  );

  always #5 clk = ~clk;

  // Word-level result of an operation.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Word-level compare flag of an operation.
  function automatic logic ref_cmp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (o)
      OP_SUB:  return a >= b;
      OP_SLT:  return $signed(a) < $signed(b);
      OP_SLTU: return a < b;
      OP_EQ:   return a == b;
      default: return s[32];
    endcase
  endfunction

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Cycle-level expectation: busy window, counter, done pulse and cmp.
  logic        m_busy = 1'b0;
  logic [4:0]  m_cnt  = 5'd0;
  logic        m_done = 1'b0;
  logic        m_cmp  = 1'b0;
  logic [2:0]  m_op   = 3'd0;
  logic [31:0] m_a    = 32'd0;
  logic [31:0] m_b    = 32'd0;
  logic        chk_en = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0;
      m_cnt  <= 5'd0;
      m_done <= 1'b0;
      m_cmp  <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 5'd31) begin
        m_busy <= 1'b0;
        m_cnt  <= 5'd0;
        m_done <= 1'b1;
        m_cmp  <= ref_cmp(m_op, m_a, m_b);
      end else begin
        m_cnt  <= m_cnt + 5'd1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 5'd0;
        m_op   <= op_in;
        m_a    <= cur_a;
        m_b    <= cur_b;
      end
    end
  end

  // Compare every output on every falling edge.
  always @(negedge clk) begin
    logic [31:0] r;
    if (chk_en) begin
      r = ref_res(m_op, m_a, m_b);
      check1("busy",    busy,    m_busy);
      check1("counter", counter, m_cnt);
      check1("done",    done,    m_done);
      check1("cmp",     cmp,     m_cmp);
      check1("d_bit",   d_bit,   m_busy ? r[m_cnt] : 1'b0);
    end
  end

  // Starts an op at the current time (a falling edge), collects the d_bit
  // stream until done, and optionally checks literal expectations.
  // poke_at >= 0 pulses a spurious start when the counter reaches that value.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit has_exp, input logic [31:0] exp_res, input logic exp_cmp, input int poke_at);
    logic [31:0] acc;
    int          ncyc;
    bit          got_done;
    op_in = o;
    cur_a = a;
    cur_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = 32'd0;
    ncyc = 0;
    got_done = 1'b0;
    while (!got_done && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (busy) acc[counter] = d_bit;
      if (done) got_done = 1'b1;
      if (!got_done && poke_at >= 0 && busy && int'(counter) == poke_at) begin
        start = 1'b1;
        op_in = o ^ 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL %s timeout: no done within 40 cycles", tag);
    end
    if (has_exp) begin
      check1({tag, " result"},  acc,  exp_res);
      check1({tag, " cmp"},     cmp,  exp_cmp);
      check1({tag, " latency"}, ncyc, 32'd33);
      check1({tag, " model result"}, ref_res(o, a, b), exp_res);
      check1({tag, " model cmp"},    ref_cmp(o, a, b), exp_cmp);
    end
  endtask

  initial begin
    int          k;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          hit;

    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check1("reset busy",    busy,    1'b0);
    check1("reset counter", counter, 5'd0);
    check1("reset done",    done,    1'b0);
    check1("reset cmp",     cmp,     1'b0);
    check1("reset d_bit",   d_bit,   1'b0);
    rstn   = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Directed cases; consecutive calls start in the done cycle (no gap).
    run_op("add_carry", OP_ADD,  32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1, -1);
    run_op("sub_5_7",   OP_SUB,  32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, -1);
    run_op("slt_5_7",   OP_SLT,  32'd5,        32'd7,        1'b1, 32'h00000000, 1'b1, -1);
    run_op("sltu_5_7",  OP_SLTU, 32'd5,        32'd7,        1'b1, 32'h00000000, 1'b1, -1);
    run_op("slt_neg",   OP_SLT,  32'h80000000, 32'h00000001, 1'b1, 32'h00000000, 1'b1, -1);
    run_op("sltu_big",  OP_SLTU, 32'h80000000, 32'h00000001, 1'b1, 32'h00000000, 1'b0, -1);
    run_op("eq_same",   OP_EQ,   32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, -1);
    run_op("eq_bit31",  OP_EQ,   32'h12345678, 32'h92345678, 1'b1, 32'h00000000, 1'b0, -1);
    run_op("xor_poke",  OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0FF00FF0, 1'b1, 10);
    // Back-to-back start in the done cycle: busy must be up right away.
    op_in = OP_ADD; cur_a = 32'hFFFFFFFF; cur_b = 32'h00000001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check1("no_gap busy",    busy,    1'b1);
    check1("no_gap counter", counter, 5'd0);

    // Let that ADD finish so cmp=1, then abort the next ADD at counter 17.
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    check1("pre_abort cmp", cmp, 1'b1);
    op_in = OP_ADD; cur_a = 32'h00001234; cur_b = 32'h00000001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    k = 0;
    while (!hit && k < 40) begin
      @(negedge clk);
      k++;
      if (counter == 5'd17) hit = 1'b1;
    end
    check1("abort reached 17", {31'd0, hit}, 32'd1);
    rstn = 1'b0;
    #1;
    check1("abort busy",    busy,    1'b0);
    check1("abort counter", counter, 5'd0);
    check1("abort done",    done,    1'b0);
    check1("abort cmp",     cmp,     1'b0);
    check1("abort d_bit",   d_bit,   1'b0);
    #2;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check1("post_abort done", done, 1'b0);
    run_op("and_after", OP_AND, 32'hFFFF0000, 32'h0FF00FF0, 1'b1, 32'h0FF00000, 1'b1, -1);

    // Randomized operations with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        2:       begin ra = ra | 32'h80000000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("rand", ro, ra, rb, 1'b0, 32'd0, 1'b0, -1);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
